mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit in the MEM stage; the initiator side of the data-memory interface.
- Converts pipeline byte/halfword/word load/store requests into whole-word accesses on the word-only data memory.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Detects misaligned, out-of-range and illegal-size requests, and stalls the pipeline while busy.

Parameters:
- ADDR_LO, `START_OF_MEMFILE, lowest legal byte address.
- ADDR_HI, `END_OF_MEMFILE, highest legal byte address (inclusive).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only when stall=0.
- req_rw  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  1=zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  high while state != IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; holds last value otherwise.
- fault  out  1  one-cycle pulse on a rejected request.
- fault_cause  out  2  01=misaligned, 10=out of range, 11=illegal size.
- dm_addr  out  32  byte address to data memory, always word-aligned (low 2 bits 0).
- dm_rw  out  1  1=write; memory commits on the negedge of any cycle with dm_rw=1.
- dm_wdata  out  32  full write word.
- dm_rdata  in  32  read word; valid before the end of the cycle in which dm_addr is presented with dm_rw=0.

Behaviour:
- Reset values: state=IDLE; stall, resp_valid, fault, dm_rw = 0; fault_cause, resp_rdata, dm_addr, dm_wdata = 0.
- All outputs are registered or decoded from state only, so dm_rw is stable at the negedge.
- States:
  - IDLE: stall=0, dm_rw=0. On a posedge with req_valid=1, latch the request and check it in priority order: illegal size, then misaligned (half with addr[0]=1; word with addr[1:0]!=0), then out of range (addr<ADDR_LO or addr>ADDR_HI).
    - Rejected -> FAULT.
    - Load -> LOAD.
    - Word store -> STORE.
    - Byte/half store -> RMW_RD.
  - FAULT (1 cycle): fault=1, cause valid, no memory access, no resp_valid -> IDLE.
  - LOAD (1 cycle): dm_addr={addr[31:2],2'b00}, dm_rw=0. At the end of the cycle, select the lane by addr[1:0] (byte) or addr[1] (half), extend, and register into resp_rdata -> IDLE with resp_valid=1 for the next cycle.
  - STORE (1 cycle): dm_rw=1, dm_wdata=req_wdata -> IDLE, resp_valid=1.
  - RMW_RD (1 cycle): dm_rw=0; capture dm_rdata into the merge register -> RMW_WR.
  - RMW_WR (1 cycle): dm_rw=1; dm_wdata = merge word with only the addressed byte/half lane replaced by req_wdata[7:0]/[15:0] -> IDLE, resp_valid=1.
- Latency from the accepting edge to resp_valid:
  - Load and word store: 1 busy cycle, resp_valid in the following cycle.
  - Sub-word store: 2 busy cycles.
- resp_rdata changes only on load completion.
- Back-to-back: a new request can be accepted in the same cycle resp_valid or fault is high (state is IDLE).
- req_valid while stall=1 is ignored; the pipeline holds its inputs.
- Reset mid-operation: a reset edge returns the block to IDLE and drops dm_rw in the next cycle.
  - Reset during RMW_RD: the write is abandoned and memory is unchanged.
  - Reset sampled at the end of STORE/RMW_WR: the negedge write in that cycle has already occurred.
- Byte address wrap is not supported; the range check rejects the address instead.

Decomposition:
- riscv.vh gains:
  - size encodings (SIZE_B, SIZE_H, SIZE_W);
  - fault cause codes;
  - LSU state encodings (3-bit).
- Reuses `BITS32, `BITS2, `TRUE/`FALSE.
- One combinational sub-module, lsu_lane: given word, addr[1:0], size and unsigned, it returns the extended load value and the merged store word. Used by both the LOAD and RMW_WR paths.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x100; load word 0x100 -> dm_rw high for 1 cycle, resp_rdata=0xDEADBEEF, each op stall=1 for exactly 1 cycle.
- Byte store RMW: memory 0x11223344 at 0x104; SB 0xAA to 0x106 -> 2 stall cycles, dm_rw=0 then 1, dm_wdata=0x11AA3344.
- Sign extension: word 0x80FF7F01 at 0x108.
  - LB 0x10A -> 0xFFFFFFFF.
  - LBU 0x10A -> 0x000000FF.
  - LH 0x10A -> 0xFFFF80FF.
  - LHU 0x108 -> 0x00007F01.
- Faults:
  - LW 0x102 -> fault=1, cause=01.
  - SW to ADDR_HI+1 -> cause=10.
  - size=11 -> cause=11.
  - In all three: dm_rw never high, no resp_valid.
- Reset mid-RMW: SH 0xBEEF to 0x10C, assert rst in the RMW_RD cycle -> IDLE next cycle, dm_rw stays 0, word at 0x10C unchanged.
- Back-to-back and stall: requests held valid continuously -> second request accepted in the resp_valid cycle; changes to inputs while stall=1 have no effect.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Size encodings, fault causes, FSM states and the request check.
package mem_lsu_pkg;

    localparam logic [31:0] LSU_ADDR_LO = 32'h0000_0000;
    localparam logic [31:0] LSU_ADDR_HI = 32'h0000_0FFF;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_MISAL = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_SIZE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FAULT  = 3'd1,
        S_LOAD   = 3'd2,
        S_STORE  = 3'd3,
        S_RMW_RD = 3'd4,
        S_RMW_WR = 3'd5
    } lsu_state_e;

    // Checks run in priority order: size, then alignment, then range.
    function automatic logic [1:0] lsu_cause(
        input logic [31:0] a,
        input logic [1:0]  sz,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (sz == SIZE_X)
            return CAUSE_SIZE;
        if ((sz == SIZE_H && a[0]) ||
            (sz == SIZE_W && a[1:0] != 2'b00))
            return CAUSE_MISAL;
        if (a < lo || a > hi)
            return CAUSE_RANGE;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline request/response and data-memory bus of the LSU.
// master = pipeline plus memory side, slave = the LSU itself.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] dm_addr;
    logic        dm_rw;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        output req_valid, req_rw, req_size, req_unsigned,
        output req_addr, req_wdata, dm_rdata,
        input  stall, resp_valid, resp_rdata, fault,
        input  fault_cause, dm_addr, dm_rw, dm_wdata
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_unsigned,
        input  req_addr, req_wdata, dm_rdata,
        output stall, resp_valid, resp_rdata, fault,
        output fault_cause, dm_addr, dm_rw, dm_wdata
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte/half lane logic shared by the load and store-merge paths.
// Returns the extended load value and the merged store word.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, extension and lane replacement.
    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        ldata  = word;
        mword  = wdata;
        case (size)
            SIZE_B: begin
                ldata = uns ? {24'h0, byte_v}
                            : {{24{byte_v[7]}}, byte_v};
                mword = word;
                mword[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                ldata = uns ? {16'h0, half_v}
                            : {{16{half_v[15]}}, half_v};
                mword = word;
                if (off[1])
                    mword[31:16] = wdata[15:0];
                else
                    mword[15:0] = wdata[15:0];
            end
            default: begin
                ldata = word;
                mword = wdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit driving a word-only data memory.
// Sub-word stores use read-modify-write; loads are extended.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = LSU_ADDR_LO,
    parameter logic [31:0] ADDR_HI = LSU_ADDR_HI
) (
    input  logic     clk,
    input  logic     rst,
    mem_lsu_if.slave bus
);
    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] merge_q;
    logic [31:0] resp_q;
    logic        resp_v_q;
    logic [1:0]  cause_q;
    logic [1:0]  cause_d;
    logic        accept;
    logic        dm_wr;
    logic [31:0] lane_word;
    logic [31:0] ld_val;
    logic [31:0] st_word;

    assign accept  = (state_q == S_IDLE) && bus.req_valid;
    assign cause_d = lsu_cause(bus.req_addr, bus.req_size,
                               ADDR_LO, ADDR_HI);
    assign dm_wr   = (state_q == S_STORE) || (state_q == S_RMW_WR);

    assign lane_word = (state_q == S_RMW_WR) ? merge_q
                                             : bus.dm_rdata;

    mem_lsu_lane u_lane (
        .word  (lane_word),
        .off   (r_addr[1:0]),
        .size  (r_size),
        .uns   (r_uns),
        .wdata (r_wdata),
        .ldata (ld_val),
        .mword (st_word)
    );

    assign bus.stall       = (state_q != S_IDLE);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.fault_cause = cause_q;
    assign bus.resp_valid  = resp_v_q;
    assign bus.resp_rdata  = resp_q;
    assign bus.dm_addr     = {r_addr[31:2], 2'b00};
    assign bus.dm_rw       = dm_wr;
    assign bus.dm_wdata    = dm_wr ? st_word : 32'h0;

    // Next-state decode; every busy state lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cause_d != CAUSE_NONE)
                        state_d = S_FAULT;
                    else if (!bus.req_rw)
                        state_d = S_LOAD;
                    else if (bus.req_size == SIZE_W)
                        state_d = S_STORE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_RMW_RD: state_d = S_RMW_WR;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, latched request, merge word and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            merge_q  <= 32'h0;
            resp_q   <= 32'h0;
            resp_v_q <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            resp_v_q <= (state_q == S_LOAD) || dm_wr;
            if (accept) begin
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                cause_q <= cause_d;
            end
            if (state_q == S_LOAD)
                resp_q <= ld_val;
            if (state_q == S_RMW_RD)
                merge_q <= bus.dm_rdata;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural word memory.
// Expected responses and writes are queued as requests are issued.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    exp_t        sbq[$];
    wr_t         wq[$];
    exp_t        e_cur;
    wr_t         w_cur;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] mem [0:1023];

    mem_lsu_if bus();

    mem_lsu #(
        .ADDR_LO (32'h0000_0000),
        .ADDR_HI (32'h0000_0FFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.dm_rdata = mem[bus.dm_addr[11:2]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic exp_load(input logic [31:0] d);
        sbq.push_back('{1'b0, 2'b00, d});
        last_rd = d;
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a, d});
        sbq.push_back('{1'b0, 2'b00, last_rd});
    endtask

    task automatic exp_fault(input logic [1:0] c);
        sbq.push_back('{1'b1, c, 32'h0});
    endtask

    task automatic op(input logic rw, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_busy,
                      input logic [3:0] exp_pat, input string nm);
        int busy;
        logic [3:0] pat;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_rw       = rw;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        busy = 0;
        pat  = 4'b0;
        while (busy < 7) begin
            @(negedge clk);
            if (!bus.stall) break;
            pat = {pat[2:0], bus.dm_rw};
            busy++;
        end
        chk({nm, "_busy"}, busy, exp_busy);
        chk({nm, "_rwpat"}, {28'h0, pat}, {28'h0, exp_pat});
    endtask

    // Monitor: memory writes on negedge and response scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.resp_valid || bus.fault)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", {30'h0, bus.fault, bus.resp_valid},
                    32'h0);
            end else begin
                e_cur = sbq.pop_front();
                chk("out_fault", {31'h0, bus.fault},
                    {31'h0, e_cur.is_fault});
                chk("out_resp", {31'h0, bus.resp_valid},
                    {31'h0, !e_cur.is_fault});
                if (e_cur.is_fault)
                    chk("fault_cause", {30'h0, bus.fault_cause},
                        {30'h0, e_cur.cause});
                else
                    chk("resp_rdata", bus.resp_rdata, e_cur.data);
            end
        end
        if (bus.dm_rw) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {31'h0, bus.dm_rw}, 32'h0);
            end else begin
                w_cur = wq.pop_front();
                chk("dm_addr", bus.dm_addr, w_cur.a);
                chk("dm_wdata", bus.dm_wdata, w_cur.d);
            end
            mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_rw       = 1'b0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_fault", {31'h0, bus.fault}, 32'h0);
        chk("rst_dm_rw", {31'h0, bus.dm_rw}, 32'h0);
        chk("rst_fault_cause", {30'h0, bus.fault_cause}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_dm_addr", bus.dm_addr, 32'h0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'h0);

        exp_store(32'h100, 32'hDEADBEEF);
        op(1, SIZE_W, 0, 32'h100, 32'hDEADBEEF, 1, 4'b0001, "sw100");
        exp_load(32'hDEADBEEF);
        op(0, SIZE_W, 0, 32'h100, 32'h0, 1, 4'b0000, "lw100");

        exp_store(32'h104, 32'h11223344);
        op(1, SIZE_W, 0, 32'h104, 32'h11223344, 1, 4'b0001, "sw104");
        exp_store(32'h108, 32'h80FF7F01);
        op(1, SIZE_W, 0, 32'h108, 32'h80FF7F01, 1, 4'b0001, "sw108");
        exp_store(32'h10C, 32'hCAFEF00D);
        op(1, SIZE_W, 0, 32'h10C, 32'hCAFEF00D, 1, 4'b0001, "sw10c");

        exp_store(32'h104, 32'h11AA3344);
        op(1, SIZE_B, 0, 32'h106, 32'h123456AA, 2, 4'b0001, "sb106");
        exp_load(32'h11AA3344);
        op(0, SIZE_W, 0, 32'h104, 32'h0, 1, 4'b0000, "lw104");

        exp_load(32'hFFFFFFFF);
        op(0, SIZE_B, 0, 32'h10A, 32'h0, 1, 4'b0000, "lb10a");
        exp_load(32'h000000FF);
        op(0, SIZE_B, 1, 32'h10A, 32'h0, 1, 4'b0000, "lbu10a");
        exp_load(32'hFFFF80FF);
        op(0, SIZE_H, 0, 32'h10A, 32'h0, 1, 4'b0000, "lh10a");
        exp_load(32'h00007F01);
        op(0, SIZE_H, 1, 32'h108, 32'h0, 1, 4'b0000, "lhu108");

        exp_store(32'hFFC, 32'h5A5A1234);
        op(1, SIZE_W, 0, 32'hFFC, 32'h5A5A1234, 1, 4'b0001, "swtop");
        exp_load(32'h5A5A1234);
        op(0, SIZE_W, 0, 32'hFFC, 32'h0, 1, 4'b0000, "lwtop");
        exp_load(32'h0000005A);
        op(0, SIZE_B, 0, 32'hFFF, 32'h0, 1, 4'b0000, "lbtop");

        exp_fault(CAUSE_MISAL);
        op(0, SIZE_W, 0, 32'h102, 32'h0, 1, 4'b0000, "f_misal");
        exp_fault(CAUSE_RANGE);
        op(1, SIZE_W, 0, 32'h1000, 32'h1, 1, 4'b0000, "f_range");
        exp_fault(CAUSE_SIZE);
        op(0, SIZE_X, 0, 32'h100, 32'h0, 1, 4'b0000, "f_size");

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_size  = SIZE_H;
        bus.req_addr  = 32'h10C;
        bus.req_wdata = 32'h1234BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rmwrd_stall", {31'h0, bus.stall}, 32'h1);
        chk("rmwrd_dm_rw", {31'h0, bus.dm_rw}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rmwrst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rmwrst_dm_rw", {31'h0, bus.dm_rw}, 32'h0);
        last_rd = 32'h0;
        exp_load(32'hCAFEF00D);
        op(0, SIZE_W, 0, 32'h10C, 32'h0, 1, 4'b0000, "lw10c");

        exp_load(32'hDEADBEEF);
        exp_load(32'h80FF7F01);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_rw       = 1'b0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h100;
        @(posedge clk);
        #1 bus.req_addr = 32'h108;
        @(negedge clk);
        chk("b2b_a_stall", {31'h0, bus.stall}, 32'h1);
        @(negedge clk);
        chk("b2b_a_idle", {31'h0, bus.stall}, 32'h0);
        chk("b2b_a_resp", {31'h0, bus.resp_valid}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_rw    = 1'b1;
        bus.req_size  = SIZE_X;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("b2b_b_accepted", {31'h0, bus.stall}, 32'h1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_done", {31'h0, bus.stall}, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'h0);
        chk("wq_empty", wq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
